// File: rtl/ssr_sync_pkg.sv
// Shared definitions for the controller/ToR time-sync and slot protocol.
package ssr_sync_pkg;

  // Control-message type codes carried on the control channel
  localparam logic [1:0] MSG_RETURN_TS = 2'd1;
  localparam logic [1:0] MSG_M_STD     = 2'd2;
  localparam logic [1:0] MSG_SIM_START = 2'd3;

  // Default slot timing, shared with the controller master
  localparam logic [31:0] DEF_SLOT_LEN     = 32'h0000_0680;
  localparam logic [31:0] DEF_CONFIG_DELAY = 32'h0000_00AA;
  localparam logic [31:0] DEF_SYNC_TIMEOUT = 32'h0000_1000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_S_TS  = 3'd1,
    ST_WAIT_RET   = 3'd2,
    ST_WAIT_M_STD = 3'd3,
    ST_RUN        = 3'd4
  } sync_state_e;

  // Corrected local time: master time plus half the round trip, plus one
  // for the cycle spent loading the value.
  function automatic logic [63:0] corrected_time(input logic [63:0] master_ts,
                                                 input logic [63:0] now,
                                                 input logic [63:0] t1);
    logic [63:0] rtt;
    rtt = now - t1;
    return master_ts + (rtt >> 1) + 64'd1;
  endfunction

endpackage

// File: rtl/ssr_local_timer.sv
// Free-running 64-bit local time counter with a synchronous load port.
module ssr_local_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [63:0] i_load_val,
  output logic [63:0] o_time
);

  logic [63:0] time_r;

  // Count every cycle; a load replaces the increment for that cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      time_r <= 64'd0;
    end else if (i_load) begin
      time_r <= i_load_val;
    end else begin
      time_r <= time_r + 64'd1;
    end
  end

  assign o_time = time_r;

endmodule

// File: rtl/tor_ts_slave.sv
// ToR-side time-sync slave: timestamp exchange, time correction and slot tracking.
module tor_ts_slave #(
  parameter logic [31:0] P_SLOT_LEN     = ssr_sync_pkg::DEF_SLOT_LEN,
  parameter logic [31:0] P_CONFIG_DELAY = ssr_sync_pkg::DEF_CONFIG_DELAY,
  parameter logic [31:0] P_SYNC_TIMEOUT = ssr_sync_pkg::DEF_SYNC_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_link_up,
  input  logic        i_rx_valid,
  input  logic [1:0]  i_rx_type,
  input  logic [63:0] i_rx_ts,
  input  logic        i_rx_slot_id,
  output logic        o_tx_valid,
  output logic [63:0] o_tx_ts,
  input  logic        i_tx_ready,
  output logic [63:0] o_local_time,
  output logic        o_slot_id,
  output logic        o_slot_active,
  output logic        o_slot_start,
  output logic        o_synced,
  output logic        o_sim_start,
  output logic        o_sync_err
);
  import ssr_sync_pkg::*;

  localparam logic [31:0] SLOT_LAST  = P_SLOT_LEN - 32'd1;
  localparam logic [31:0] MSTD_LIMIT = P_CONFIG_DELAY + P_SYNC_TIMEOUT;

  sync_state_e state_r, state_next_s;
  logic [63:0] local_time_s, load_val_s, tx_ts_r, tx_ts_s, t1_r, t1_s;
  logic [31:0] slot_cnt_r, slot_cnt_s, wait_cnt_r;
  logic        load_s, ret_s, mstd_s;
  logic        tx_valid_r, tx_valid_s, slot_id_r, slot_id_s;
  logic        slot_active_r, slot_active_s, slot_start_r, slot_start_s;
  logic        synced_r, synced_s, sync_err_r, sync_err_s, sim_start_r;

  assign ret_s  = i_rx_valid && (i_rx_type == MSG_RETURN_TS);
  assign mstd_s = i_rx_valid && (i_rx_type == MSG_M_STD);

  ssr_local_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load_s),
    .i_load_val (load_val_s),
    .o_time     (local_time_s)
  );

  // Next-state and next-output decode; link loss overrides every state
  always_comb begin
    state_next_s  = state_r;
    tx_valid_s    = tx_valid_r;
    tx_ts_s       = tx_ts_r;
    t1_s          = t1_r;
    slot_id_s     = slot_id_r;
    slot_cnt_s    = slot_cnt_r + 32'd1;
    slot_active_s = slot_active_r;
    slot_start_s  = 1'b0;
    synced_s      = synced_r;
    sync_err_s    = 1'b0;
    load_s        = 1'b0;
    load_val_s    = 64'd0;
    if (!i_link_up) begin
      state_next_s  = ST_IDLE;
      tx_valid_s    = 1'b0;
      slot_active_s = 1'b0;
      synced_s      = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Request carries the local time of the first request cycle
          state_next_s = ST_SEND_S_TS;
          tx_valid_s   = 1'b1;
          tx_ts_s      = local_time_s + 64'd1;
          synced_s     = 1'b0;
        end
        ST_SEND_S_TS: begin
          if (tx_valid_r && i_tx_ready) begin
            t1_s         = tx_ts_r;
            tx_valid_s   = 1'b0;
            state_next_s = ST_WAIT_RET;
          end else begin
            tx_valid_s = 1'b1;
          end
        end
        ST_WAIT_RET: begin
          if (ret_s) begin
            load_s       = 1'b1;
            load_val_s   = corrected_time(i_rx_ts, local_time_s, t1_r);
            synced_s     = 1'b1;
            state_next_s = ST_WAIT_M_STD;
          end else if (wait_cnt_r == P_SYNC_TIMEOUT) begin
            sync_err_s   = 1'b1;
            synced_s     = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_RET;
          end
        end
        ST_WAIT_M_STD: begin
          if (mstd_s) begin
            slot_id_s     = i_rx_slot_id;
            slot_cnt_s    = 32'd0;
            slot_start_s  = 1'b1;
            slot_active_s = 1'b1;
            state_next_s  = ST_RUN;
          end else if (wait_cnt_r == MSTD_LIMIT) begin
            sync_err_s   = 1'b1;
            synced_s     = 1'b0;
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_WAIT_M_STD;
          end
        end
        ST_RUN: begin
          // An early M_STD simply restarts the slot
          if (mstd_s) begin
            slot_id_s     = i_rx_slot_id;
            slot_cnt_s    = 32'd0;
            slot_start_s  = 1'b1;
            slot_active_s = 1'b1;
            state_next_s  = ST_RUN;
          end else if (slot_cnt_r == SLOT_LAST) begin
            slot_active_s = 1'b0;
            state_next_s  = ST_WAIT_M_STD;
          end else begin
            slot_active_s = 1'b1;
          end
        end
        default: begin
          state_next_s  = ST_IDLE;
          tx_valid_s    = 1'b0;
          slot_active_s = 1'b0;
          synced_s      = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r       <= ST_IDLE;
      tx_valid_r    <= 1'b0;
      tx_ts_r       <= 64'd0;
      t1_r          <= 64'd0;
      slot_id_r     <= 1'b0;
      slot_cnt_r    <= 32'd0;
      wait_cnt_r    <= 32'd0;
      slot_active_r <= 1'b0;
      slot_start_r  <= 1'b0;
      synced_r      <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      tx_valid_r    <= tx_valid_s;
      tx_ts_r       <= tx_ts_s;
      t1_r          <= t1_s;
      slot_id_r     <= slot_id_s;
      slot_cnt_r    <= slot_cnt_s;
      wait_cnt_r    <= (state_next_s != state_r) ? 32'd0 : wait_cnt_r + 32'd1;
      slot_active_r <= slot_active_s;
      slot_start_r  <= slot_start_s;
      synced_r      <= synced_s;
      sync_err_r    <= sync_err_s;
    end
  end

  // Sticky simulation-start flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sim_start_r <= 1'b0;
    end else if (i_rx_valid && (i_rx_type == MSG_SIM_START)) begin
      sim_start_r <= 1'b1;
    end else begin
      sim_start_r <= sim_start_r;
    end
  end

  assign o_tx_valid    = tx_valid_r;
  assign o_tx_ts       = tx_ts_r;
  assign o_local_time  = local_time_s;
  assign o_slot_id     = slot_id_r;
  assign o_slot_active = slot_active_r;
  assign o_slot_start  = slot_start_r;
  assign o_synced      = synced_r;
  assign o_sim_start   = sim_start_r;
  assign o_sync_err    = sync_err_r;

endmodule
